// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tts_pkg;

  localparam logic [1:0] StateIdleEnc  = 2'b00;
  localparam logic [1:0] StateDriveEnc = 2'b01;
  localparam logic [1:0] StateDoneEnc  = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = StateIdleEnc,
    StDrive = StateDriveEnc,
    StDone  = StateDoneEnc
  } tts_state_e;

  // Binary to reflected Gray code; wide enough for the largest N_IN.
  function automatic logic [15:0] bin2gray(input logic [15:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/tts_hold_counter.sv
// Counts the HOLD cycles a vector is presented; tc marks the final hold cycle.
module tts_hold_counter #(
  parameter int unsigned HOLD = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(HOLD - 1);

  logic [CntW-1:0] cnt_q;

  assign tc = (cnt_q == CntMax);

  // Wraps to zero after the terminal count so the next vector starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || (en && tc)) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper/checker for combinational DUTs.
// Define SWEEP_GRAY_EN to drive vectors in Gray-code order instead of binary.
module truth_table_sweeper #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 1,
  parameter int unsigned HOLD  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   vec_out,
  input  logic [N_OUT-1:0]  dut_out,
  input  logic [N_OUT-1:0]  exp_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              sample,
  output logic [N_IN:0]     err_count,
  output logic              err_seen,
  output logic [N_IN-1:0]   first_err_vec
);

  import tts_pkg::*;

  // Extra index bit keeps 2^N_IN representable without wrap ambiguity.
  localparam logic [N_IN:0] LastIdx = {1'b0, {N_IN{1'b1}}};

  tts_state_e      state_q;
  logic [N_IN:0]   idx_q;
  logic [N_IN:0]   idx_inc;
  logic [N_IN-1:0] next_vec;
  logic            launch;
  logic            hold_en;
  logic            hold_tc;
  logic            mismatch;

  assign idx_inc = idx_q + {{N_IN{1'b0}}, 1'b1};

`ifdef SWEEP_GRAY_EN
  assign next_vec = N_IN'(bin2gray(16'(idx_inc[N_IN-1:0])));
`else
  assign next_vec = idx_inc[N_IN-1:0];
`endif

  assign launch  = start && (state_q != StDrive);
  assign hold_en = (state_q == StDrive);
  assign sample  = hold_en && hold_tc;

  // Case inequality so X/Z on the DUT response counts as a failure; synthesizes as !=.
  assign mismatch = (dut_out !== exp_out);

  tts_hold_counter #(
    .HOLD (HOLD)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (launch),
    .en    (hold_en),
    .tc    (hold_tc)
  );

  // Sweep control, stimulus and error capture with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      vec_out       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      err_seen      <= 1'b0;
      first_err_vec <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q       <= StDrive;
            idx_q         <= '0;
            vec_out       <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            err_seen      <= 1'b0;
            first_err_vec <= '0;
          end
        end
        StDrive: begin
          if (sample) begin
            if (mismatch) begin
              err_count <= err_count + {{N_IN{1'b0}}, 1'b1};
              err_seen  <= 1'b1;
              if (!err_seen) first_err_vec <= vec_out;
            end
            if (idx_q == LastIdx) begin
              state_q <= StDone;
              vec_out <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= !(err_seen || mismatch);
            end else begin
              idx_q   <= idx_inc;
              vec_out <= next_vec;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed, table-driven bench for truth_table_sweeper (default and N_IN=2/HOLD=1 instances).
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;

  // Instance A: defaults (N_IN=3, N_OUT=1, HOLD=5)
  logic       start_a;
  logic [2:0] vec_a;
  logic [0:0] dut_a;
  logic [0:0] exp_a;
  logic       busy_a, done_a, pass_a, sample_a, err_seen_a;
  logic [3:0] err_a;
  logic [2:0] first_a;
  int         mode_a;

  // Instance B: N_IN=2, HOLD=1, golden always inverted
  logic       start_b;
  logic [1:0] vec_b;
  logic [0:0] dut_b;
  logic [0:0] exp_b;
  logic       busy_b, done_b, pass_b, sample_b, err_seen_b;
  logic [2:0] err_b;
  logic [1:0] first_b;

  int n_checks;
  int n_errors;

  truth_table_sweeper u_dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start_a),
    .vec_out       (vec_a),
    .dut_out       (dut_a),
    .exp_out       (exp_a),
    .busy          (busy_a),
    .done          (done_a),
    .pass          (pass_a),
    .sample        (sample_a),
    .err_count     (err_a),
    .err_seen      (err_seen_a),
    .first_err_vec (first_a)
  );

  truth_table_sweeper #(
    .N_IN  (2),
    .N_OUT (1),
    .HOLD  (1)
  ) u_dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start_b),
    .vec_out       (vec_b),
    .dut_out       (dut_b),
    .exp_out       (exp_b),
    .busy          (busy_b),
    .done          (done_b),
    .pass          (pass_b),
    .sample        (sample_b),
    .err_count     (err_b),
    .err_seen      (err_seen_b),
    .first_err_vec (first_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Example 3-input DUT; the golden copy is corrupted per mode to plant mismatches.
  always_comb begin
    dut_a = (vec_a[0] & vec_a[1]) | vec_a[2];
    exp_a = dut_a;
    if ((mode_a == 1 && vec_a == 3'd5) || (mode_a == 2) || (mode_a == 3 && vec_a >= 3'd6))
      exp_a = ~dut_a;
  end

  always_comb begin
    dut_b = ^vec_b;
    exp_b = ~dut_b;
  end

  function automatic int model_vec(input int i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One sweep on instance A; restart_at >= 0 pulses start mid-sweep at that cycle.
  task automatic run_a(input int mode, input int restart_at,
                       output int done_cyc, output int n_samp, output int bad);
    logic [2:0] prev;
    mode_a   = mode;
    done_cyc = -1;
    n_samp   = 0;
    bad      = 0;
    prev     = '0;
    start_a  = 1'b1;
    @(posedge clk); #1;
    start_a  = 1'b0;
    check($sformatf("clear_on_start(mode %0d)", mode),
          32'({err_a, first_a, done_a, pass_a, err_seen_a}), 32'd0);
    for (int c = 0; c <= 60; c++) begin
      if (done_a) begin
        done_cyc = c;
        break;
      end
      if ({29'd0, vec_a} !== model_vec(c / 5) || busy_a !== 1'b1 ||
          sample_a !== ((c % 5) == 4))
        bad++;
      if (sample_a) begin
        n_samp++;
`ifdef SWEEP_GRAY_EN
        if (n_samp > 1 && $countones(prev ^ vec_a) != 1) bad++;
`else
        if (n_samp > 1 && vec_a != prev + 3'd1) bad++;
`endif
        prev = vec_a;
      end
      start_a = (c == restart_at);
      @(posedge clk); #1;
    end
    start_a = 1'b0;
  endtask

  typedef struct {
    int   mode;
    int   restart_at;
    int   err;
    int   first;
    logic pass;
  } vec_t;

  vec_t tbl[5];
  int   dc, ns, bad;

  initial begin
    tbl[0] = '{mode: 0, restart_at: -1, err: 0, first: 0, pass: 1'b1};
    tbl[1] = '{mode: 1, restart_at: -1, err: 1, first: 5, pass: 1'b0};
    tbl[2] = '{mode: 2, restart_at: -1, err: 8, first: 0, pass: 1'b0};
    tbl[3] = '{mode: 0, restart_at: 12, err: 0, first: 0, pass: 1'b1};
    tbl[4] = '{mode: 3, restart_at: 12, err: 2, first: 6, pass: 1'b0};

    n_checks = 0;
    n_errors = 0;
    mode_a   = 0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", 32'({busy_a, done_a, pass_a, sample_a, vec_a, err_a, err_seen_a, first_a}),
          32'd0);
    check("reset_b", 32'({busy_b, done_b, pass_b, sample_b, vec_b, err_b, err_seen_b, first_b}),
          32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_until_start", 32'({busy_a, done_a}), 32'd0);

    // Table-driven sweeps, back to back so each restart comes from DONE
    for (int i = 0; i < 5; i++) begin
      run_a(tbl[i].mode, tbl[i].restart_at, dc, ns, bad);
      check($sformatf("done_cycle[%0d]", i), dc, 40);
      check($sformatf("sample_count[%0d]", i), ns, 8);
      check($sformatf("vec_sequence[%0d]", i), bad, 0);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("err_count[%0d]", i), 32'(err_a), tbl[i].err);
      check($sformatf("err_seen[%0d]", i), 32'(err_seen_a), 32'(tbl[i].err != 0));
      check($sformatf("first_err_vec[%0d]", i), 32'(first_a), tbl[i].first);
      check($sformatf("pass[%0d]", i), 32'(pass_a), 32'(tbl[i].pass));
      check($sformatf("done_sticky[%0d]", i), 32'(done_a), 32'd1);
      check($sformatf("done_outputs[%0d]", i), 32'({busy_a, sample_a, vec_a}), 32'd0);
    end

    // N_IN=2, HOLD=1: every vector fails, count reaches 2^N_IN without overflow
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    dc = -1; ns = 0; bad = 0;
    for (int c = 0; c <= 20; c++) begin
      if (done_b) begin
        dc = c;
        break;
      end
      if ({30'd0, vec_b} !== model_vec(c) || sample_b !== 1'b1 || busy_b !== 1'b1) bad++;
      if (sample_b) ns++;
      @(posedge clk); #1;
    end
    check("b_done_cycle", dc, 4);
    check("b_sample_count", ns, 4);
    check("b_vec_sequence", bad, 0);
    check("b_err_count", 32'(err_b), 32'd4);
    check("b_err_seen", 32'(err_seen_b), 32'd1);
    check("b_first_err_vec", 32'(first_b), 32'd0);
    check("b_pass", 32'(pass_b), 32'd0);

    // Asynchronous reset mid-sweep at cycle 17
    mode_a  = 2;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("pre_reset_err_count", 32'(err_a), 32'd3);
    check("pre_reset_busy", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_a",
          32'({busy_a, done_a, pass_a, sample_a, vec_a, err_a, err_seen_a, first_a}), 32'd0);
    check("async_reset_b", 32'({done_b, err_b, err_seen_b}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_reset",
          32'({busy_a, done_a, pass_a, sample_a, vec_a, err_a}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
